// File: rtl/packed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packed_pkg : shared sizes and types for the packed port loader        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package packed_pkg;

  localparam int DATA_WIDTH  = 512;
  localparam int PORT_SIZE   = 32;
  localparam int SWITCH_SIZE = PORT_SIZE / 2;

  typedef logic [DATA_WIDTH-1:0] port_word_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/packed_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packed_frame_bank : one ping-pong bank (words, settings, fill state)  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module packed_frame_bank
  import packed_pkg::*;
#(
  parameter int  DATA_WIDTH  = packed_pkg::DATA_WIDTH,
  parameter int  PORT_SIZE   = packed_pkg::PORT_SIZE,
  parameter int  SWITCH_SIZE = packed_pkg::SWITCH_SIZE,
  localparam int IDX_W       = $clog2(PORT_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_wr_en,
  input  logic [IDX_W-1:0]                     i_wr_idx,
  input  logic [DATA_WIDTH-1:0]                i_wr_data,
  input  logic                                 i_first,
  input  logic                                 i_close,
  input  logic [SWITCH_SIZE-1:0]               i_sw_set,
  input  logic                                 i_release,
  output bank_state_e                          o_state,
  output logic [0:PORT_SIZE-1][DATA_WIDTH-1:0] o_words,
  output logic [SWITCH_SIZE-1:0]               o_sw_set
);

  bank_state_e                          r_state;
  bank_state_e                          w_state_nxt;
  logic [0:PORT_SIZE-1][DATA_WIDTH-1:0] r_words;
  logic [SWITCH_SIZE-1:0]               r_sw_set;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY, FILLING: if (i_wr_en) w_state_nxt = i_close ? FULL : FILLING;
      FULL:           if (i_release) w_state_nxt = EMPTY;
      default:        w_state_nxt = EMPTY;
    endcase
  end

  // Clearing on release keeps the unwritten tail of a short frame at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || i_release) begin
      r_words  <= '0;
      r_sw_set <= '0;
    end else if (i_wr_en) begin
      r_words[i_wr_idx] <= i_wr_data;
      if (i_first) r_sw_set <= i_sw_set;
    end
  end

  assign o_state  = r_state;
  assign o_words  = r_words;
  assign o_sw_set = r_sw_set;

endmodule
`default_nettype wire

// File: rtl/packed_port_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packed_port_loader : serial words -> double-buffered packed frames    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module packed_port_loader
  import packed_pkg::*;
#(
  parameter int DATA_WIDTH  = packed_pkg::DATA_WIDTH,
  parameter int PORT_SIZE   = packed_pkg::PORT_SIZE,
  parameter int SWITCH_SIZE = packed_pkg::SWITCH_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 I_VALID,
  output logic                                 I_READY,
  input  logic [DATA_WIDTH-1:0]                I_DATA,
  input  logic                                 I_LAST,
  input  logic [SWITCH_SIZE-1:0]               I_SWITCH_SET,
  output logic                                 O_VALID,
  input  logic                                 O_READY,
  output logic [DATA_WIDTH-1:0][0:PORT_SIZE-1] O_PORT,
  output logic [SWITCH_SIZE-1:0]               O_SWITCH_SET,
  output logic                                 O_ERR
);

  localparam int               IDX_W      = $clog2(PORT_SIZE);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(PORT_SIZE - 1);

  logic                                 r_wr_bank;
  logic                                 r_rd_bank;
  logic [IDX_W-1:0]                     r_wr_idx;
  logic                                 r_err;

  bank_state_e                          w_state  [2];
  logic [0:PORT_SIZE-1][DATA_WIDTH-1:0] w_words  [2];
  logic [SWITCH_SIZE-1:0]               w_sw_set [2];
  logic [0:PORT_SIZE-1][DATA_WIDTH-1:0] w_rd_words;
  logic                                 w_accept;
  logic                                 w_at_end;
  logic                                 w_close;
  logic                                 w_release;

  assign I_READY   = (w_state[r_wr_bank] != FULL);
  assign w_accept  = I_VALID && I_READY;
  assign w_at_end  = (r_wr_idx == c_last_idx);
  assign w_close   = w_accept && (I_LAST || w_at_end);
  assign O_VALID   = (w_state[r_rd_bank] == FULL);
  assign w_release = O_VALID && O_READY;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic c_id = 1'(b);
      packed_frame_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PORT_SIZE   (PORT_SIZE),
        .SWITCH_SIZE (SWITCH_SIZE)
      ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept && (r_wr_bank == c_id)),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (I_DATA),
        .i_first   (r_wr_idx == '0),
        .i_close   (w_close),
        .i_sw_set  (I_SWITCH_SET),
        .i_release (w_release && (r_rd_bank == c_id)),
        .o_state   (w_state[b]),
        .o_words   (w_words[b]),
        .o_sw_set  (w_sw_set[b])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      // Error when the frame length disagrees with I_LAST: short, or full without I_LAST.
      r_err <= w_close && (I_LAST != w_at_end);
      if (w_close) begin
        r_wr_idx  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_accept) begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign w_rd_words   = w_words[r_rd_bank];
  assign O_SWITCH_SET = w_sw_set[r_rd_bank];
  assign O_ERR        = r_err;

  // Bank storage is word-major; the stage wants bit-major with port as the inner index.
  always_comb begin
    O_PORT = '0;
    for (int p = 0; p < PORT_SIZE; p++) begin
      for (int d = 0; d < DATA_WIDTH; d++) begin
        O_PORT[d][p] = w_rd_words[p][d];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packed_port_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_packed_port_loader : directed + random bench with a frame model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_packed_port_loader;
  import packed_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int PS = PORT_SIZE;
  localparam int SS = SWITCH_SIZE;

  typedef logic [0:PS-1][DW-1:0] frame_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  I_VALID;
  logic                  I_READY;
  logic [DW-1:0]         I_DATA;
  logic                  I_LAST;
  logic [SS-1:0]         I_SWITCH_SET;
  logic                  O_VALID;
  logic                  O_READY;
  logic [DW-1:0][0:PS-1] O_PORT;
  logic [SS-1:0]         O_SWITCH_SET;
  logic                  O_ERR;

  always #5 clk = ~clk;

  packed_port_loader #(
    .DATA_WIDTH  (DW),
    .PORT_SIZE   (PS),
    .SWITCH_SIZE (SS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .I_VALID      (I_VALID),
    .I_READY      (I_READY),
    .I_DATA       (I_DATA),
    .I_LAST       (I_LAST),
    .I_SWITCH_SET (I_SWITCH_SET),
    .O_VALID      (O_VALID),
    .O_READY      (O_READY),
    .O_PORT       (O_PORT),
    .O_SWITCH_SET (O_SWITCH_SET),
    .O_ERR        (O_ERR)
  );

  int  checks   = 0;
  int  errors   = 0;
  int  cyc      = 0;
  int  last_rel = -1;
  int  n_rel    = 0;
  bit  chk_gap  = 0;
  bit  rnd_rdy  = 0;
  bit  last_acc = 0;

  // Reference model: queue of completed frames awaiting the stage, plus the one being filled.
  frame_t        m_frames[$];
  logic [SS-1:0] m_sws[$];
  frame_t        m_cur;
  logic [SS-1:0] m_cur_sw;
  int            m_idx;
  logic          m_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic port_word_t get_port(input int p);
    port_word_t r;
    for (int d = 0; d < DW; d++) r[d] = O_PORT[d][p];
    return r;
  endfunction

  function automatic port_word_t rand_word();
    port_word_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_frames.delete();
    m_sws.delete();
    m_cur    = '0;
    m_cur_sw = '0;
    m_idx    = 0;
    m_err    = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model, then step the DUT.
  task automatic cycle();
    logic acc, rel;
    acc = I_VALID && I_READY;
    rel = O_VALID && O_READY;
    if (rst_n) begin
      chk("i_ready", I_READY, m_frames.size() < 2);
      chk("o_valid", O_VALID, m_frames.size() > 0);
      if (rel && m_frames.size() > 0) begin
        for (int p = 0; p < PS; p++) chk($sformatf("port%0d", p), get_port(p), m_frames[0][p]);
        chk("o_switch_set", O_SWITCH_SET, m_sws[0]);
        if (chk_gap && last_rel >= 0) chk("release_gap", cyc - last_rel, 32);
        last_rel = cyc;
        n_rel++;
      end
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rel && m_frames.size() > 0) begin
        void'(m_frames.pop_front());
        void'(m_sws.pop_front());
      end
      m_err = 1'b0;
      if (acc) begin
        if (m_idx == 0) m_cur_sw = I_SWITCH_SET;
        m_cur[m_idx] = I_DATA;
        if (I_LAST || m_idx == PS - 1) begin
          m_err = (m_idx != PS - 1) ? 1'b1 : !I_LAST;
          m_frames.push_back(m_cur);
          m_sws.push_back(m_cur_sw);
          m_cur    = '0;
          m_cur_sw = '0;
          m_idx    = 0;
        end else begin
          m_idx++;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    chk("o_err", O_ERR, m_err);
  endtask

  task automatic send_word(input port_word_t d, input logic l, input logic [SS-1:0] s);
    bit done;
    done         = 0;
    I_VALID      = 1'b1;
    I_DATA       = d;
    I_LAST       = l;
    I_SWITCH_SET = s;
    for (int n = 0; n < 200 && !done; n++) begin
      if (rnd_rdy) O_READY = 1'($urandom_range(0, 1));
      cycle();
      done = last_acc;
    end
    I_VALID = 1'b0;
    I_LAST  = 1'b0;
    chk("send_timeout", done, 1'b1);
  endtask

  task automatic send_frame(input int len, input bit with_last);
    logic [SS-1:0] sw;
    sw = SS'($urandom);
    for (int k = 0; k < len; k++) send_word(rand_word(), with_last && (k == len - 1), sw);
  endtask

  initial begin
    int            hold_acc;
    int            c0;
    port_word_t    held;
    logic [SS-1:0] held_sw;

    rst_n = 1'b0; I_VALID = 1'b0; I_DATA = '0; I_LAST = 1'b0;
    I_SWITCH_SET = '0; O_READY = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("rst_i_ready", I_READY, 1'b1);
    chk("rst_o_valid", O_VALID, 1'b0);
    chk("rst_o_port_nonzero", |O_PORT, 1'b0);
    chk("rst_o_switch_set", O_SWITCH_SET, '0);
    chk("rst_o_err", O_ERR, 1'b0);

    // Counting frame with settings on the first word.
    for (int k = 0; k < PS; k++)
      send_word(DW'(k), k == PS - 1, (k == 0) ? SS'('hA5A5) : SS'(0));
    chk("t1_o_valid", O_VALID, 1'b1);
    for (int p = 0; p < PS; p++) chk($sformatf("t1_port%0d", p), get_port(p), DW'(p));
    chk("t1_switch_set", O_SWITCH_SET, SS'('hA5A5));
    chk("t1_o_err", O_ERR, 1'b0);
    O_READY = 1'b1;
    cycle();

    // Backpressure: two frames absorbed, third stalls until one release.
    O_READY = 1'b0;
    send_frame(PS, 1);
    send_frame(PS, 1);
    held = rand_word();
    held_sw = SS'($urandom);
    I_VALID = 1'b1; I_DATA = held; I_LAST = 1'b0; I_SWITCH_SET = held_sw;
    hold_acc = 0;
    repeat (5) begin
      cycle();
      hold_acc += int'(last_acc);
    end
    chk("t2_no_accept_when_full", hold_acc, 0);
    chk("t2_i_ready_low", I_READY, 1'b0);
    O_READY = 1'b1;
    cycle();
    O_READY = 1'b0;
    chk("t2_i_ready_rise", I_READY, 1'b1);
    send_word(held, 1'b0, held_sw);
    O_READY = 1'b1;
    for (int k = 1; k < PS; k++) send_word(rand_word(), k == PS - 1, SS'($urandom));
    repeat (3) cycle();
    chk("t2_drained", O_VALID, 1'b0);

    // Continuous streaming at full rate.
    last_rel = -1;
    n_rel    = 0;
    chk_gap  = 1;
    c0       = cyc;
    for (int f = 0; f < 10; f++) send_frame(PS, 1);
    chk("t3_cycles", cyc - c0, 10 * PS);
    cycle();
    chk_gap = 0;
    chk("t3_frames", n_rel, 10);

    // Short frame of five words.
    O_READY = 1'b0;
    for (int k = 1; k <= 5; k++) send_word(DW'(k), k == 5, (k == 1) ? SS'('h1234) : SS'(0));
    chk("t4_o_err", O_ERR, 1'b1);
    for (int p = 0; p < PS; p++)
      chk($sformatf("t4_port%0d", p), get_port(p), (p < 5) ? DW'(p + 1) : DW'(0));
    send_frame(PS, 1);
    O_READY = 1'b1;
    repeat (3) cycle();

    // Full frame with no I_LAST; next word opens a new frame.
    send_frame(PS, 0);
    chk("t5_o_err", O_ERR, 1'b1);
    send_frame(PS, 1);
    repeat (3) cycle();

    // Reset with one bank full and the other part-filled.
    O_READY = 1'b0;
    send_frame(PS, 1);
    send_frame(17, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_o_valid", O_VALID, 1'b0);
    chk("t6_o_port_nonzero", |O_PORT, 1'b0);
    chk("t6_i_ready", I_READY, 1'b1);
    chk("t6_switch_set", O_SWITCH_SET, '0);
    send_frame(PS, 1);
    O_READY = 1'b1;
    repeat (3) cycle();

    // Random lengths, idle gaps and downstream readiness.
    rnd_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      int            len;
      bit            nolast;
      logic [SS-1:0] sw;
      nolast = ($urandom_range(0, 3) == 0);
      len    = nolast ? PS : $urandom_range(2, PS);
      sw     = SS'($urandom);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          O_READY = 1'($urandom_range(0, 1));
          I_DATA  = rand_word();
          cycle();
        end
        send_word(rand_word(), !nolast && (k == len - 1), sw);
      end
    end
    rnd_rdy = 0;
    O_READY = 1'b1;
    repeat (4) cycle();
    chk("final_o_valid", O_VALID, 1'b0);
    chk("final_i_ready", I_READY, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packed_port_loader.md
# packed_port_loader

Upstream feeder for the packed switching stage. Accepts a serial stream of `DATA_WIDTH`-bit words, one per handshake, and assembles `PORT_SIZE` consecutive words into one frame. Presents each frame as a full packed port vector, together with the switch settings captured for it, on a valid/ready interface. Ping-pong double buffering lets frame N+1 fill while frame N waits on the stage, so the network sees one frame per `PORT_SIZE` input cycles.

## Interface
- `DATA_WIDTH`, 512, width of one port word
- `PORT_SIZE`, 32, ports per frame; power of two, ≥ 2
- `SWITCH_SIZE`, `PORT_SIZE/2`, switch-control bits per frame
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `I_VALID`  in  1  input word valid
- `I_READY`  out  1  loader can accept a word
- `I_DATA`  in  `DATA_WIDTH`  port word
- `I_LAST`  in  1  marks the final word of a frame
- `I_SWITCH_SET`  in  `SWITCH_SIZE`  switch settings; sampled on a frame's first accepted word
- `O_VALID`  out  1  full frame available
- `O_READY`  in  1  downstream stage accepts the frame
- `O_PORT`  out  `[DATA_WIDTH-1:0][0:PORT_SIZE-1]`  frame, same packed shape as the stage input; port p = p-th word of the frame
- `O_SWITCH_SET`  out  `SWITCH_SIZE`  settings captured with the frame
- `O_ERR`  out  1  one-cycle pulse on a frame-length mismatch

## Operation
- Two banks, B0 and B1. Each holds `PORT_SIZE` words, a `SWITCH_SIZE` setting register and a state: EMPTY, FILLING or FULL.
- Write side: `wr_bank` (1 bit) and `wr_idx` (`$clog2(PORT_SIZE)` bits).
  - A word is accepted when `I_VALID && I_READY`. It is stored at slot `wr_idx` of `wr_bank`.
  - `I_READY` = state of `wr_bank` is not FULL. It depends only on registered state, with no combinational path from `O_READY`.
  - First accepted word (`wr_idx==0`): bank goes EMPTY→FILLING and `I_SWITCH_SET` is captured.
  - Frame closes on the accepted word with `I_LAST=1`, or with `wr_idx==PORT_SIZE-1`, whichever comes first. On close, the bank goes to FULL, `wr_idx` returns to 0 and `wr_bank` toggles.
  - Close with `I_LAST=1` and `wr_idx<PORT_SIZE-1`: short frame. Unwritten slots stay 0 and `O_ERR` pulses.
  - Close with `wr_idx==PORT_SIZE-1` and `I_LAST=0`: `O_ERR` pulses, the frame is complete, and the next word starts a new frame.
  - `PORT_SIZE=1`-style single-word frames are not supported.
- Read side: `rd_bank` (1 bit).
  - `O_VALID` = `rd_bank` is FULL.
  - `O_PORT` and `O_SWITCH_SET` are muxed from `rd_bank` and stay stable while `O_VALID && !O_READY`.
  - Release on `O_VALID && O_READY`: bank goes to EMPTY, all of its slots and its setting register clear to 0, and `rd_bank` toggles.
- Simultaneous events:
  - Closing one bank and releasing the other in the same cycle: both take effect.
  - A bank being released is never the write target in the same cycle, because `I_READY` was 0 for it.
- Reset: both banks EMPTY and zeroed, `wr_bank=rd_bank=0`, `wr_idx=0`. Reset mid-frame discards both partial and full frames.

## Timing
- Reset values: `I_READY=1`, `O_VALID=0`, `O_PORT=0`, `O_SWITCH_SET=0`, `O_ERR=0`.
- Latency: closing word accepted at edge t → `O_VALID=1` from edge t+1.
- `O_ERR` is registered and asserts for the one cycle after the closing edge.
- Throughput:
  - With `O_READY` held 1, `I_READY` never drops, giving `PORT_SIZE` cycles per frame.
  - With `O_READY` held 0, exactly 2 frames are absorbed, then `I_READY=0`.
  - `I_READY` returns to 1 the cycle after the first release.
- Gaps in `I_VALID` mid-frame are allowed and leave `wr_idx` unchanged.

## Structure
- Shared package `packed_pkg`:
  - `DATA_WIDTH`, `PORT_SIZE`, `SWITCH_SIZE` defaults
  - `port_word_t` (logic `[DATA_WIDTH-1:0]`)
  - `bank_state_e` {EMPTY, FILLING, FULL}
- One natural sub-module, `packed_frame_bank`: one bank holding the word array, setting register, state, slot write and clear. It is instantiated twice. Top level holds the pointers, handshake and error logic.

## Test plan
- Reset, then 32 words `I_DATA=k` (k=0..31) back-to-back with `I_LAST` on k=31 and `I_SWITCH_SET=16'hA5A5` on k=0. Required: `O_VALID` the cycle after k=31, port p = p, `O_SWITCH_SET=16'hA5A5`, `O_ERR=0`.
- `O_READY=0`, stream 3 frames. Required: `I_READY` falls after 64 accepted words. Then pulse `O_READY` once: `I_READY` rises the next cycle, and frames exit in order 0,1,2 with matching settings.
- Continuous streaming with `O_READY=1` for 10 frames. Required: `I_READY` never deasserts, and one frame exits every 32 cycles.
- `I_LAST` on the 5th word (values 1..5). Required: ports 0..4 = 1..5, ports 5..31 = 0, one-cycle `O_ERR`, and the next word starts a new frame at port 0.
- 32 words with no `I_LAST`. Required: frame closes, `O_ERR` pulses, and word 33 lands in port 0 of the other bank.
- Assert `rst_n=0` for one cycle while one bank is FULL and the other is at `wr_idx=17`. Required: `O_VALID=0`, `O_PORT=0`, `I_READY=1`, and the next frame is assembled from port 0 in B0.
